// File: rtl/gcd_sched_if.sv
// gcd_sched_if: requester and GCD-engine signal bundle.
// The master side is the requester/engine environment; the slave side is the scheduler.
interface gcd_sched_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           eng_start;
  logic [W-1:0]   eng_a;
  logic [W-1:0]   eng_b;
  logic           eng_done;
  logic [W-1:0]   eng_result;

  modport master (
    output req_valid, req_a, req_b,
    output rsp_ready, eng_done, eng_result,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_err, eng_start, eng_a, eng_b
  );

  modport slave (
    input  req_valid, req_a, req_b,
    input  rsp_ready, eng_done, eng_result,
    output req_ready, rsp_valid, rsp_data,
    output rsp_err, eng_start, eng_a, eng_b
  );
endinterface

// File: rtl/gcd_sched.sv
// gcd_sched: round-robin arbiter sharing one GCD engine among N requesters.
// Zero operands bypass the engine; a silent engine is aborted after TMO wait cycles.
module gcd_sched #(
  parameter int N   = 4,
  parameter int W   = 32,
  parameter int TMO = 255
) (
  input logic        clk,
  input logic        rst,
  gcd_sched_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] g_q, g_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  data_q, data_d;
  logic          err_q, err_d;

  logic          found;
  logic [IW-1:0] pick;
  logic [N-1:0]  hi;
  logic [N-1:0]  src;
  logic [W-1:0]  ra;
  logic [W-1:0]  rb;

  // Requests at or above rr_q win; otherwise wrap to the lowest set bit.
  always_comb begin
    hi    = bus.req_valid & ~((N'(1) << rr_q) - N'(1));
    src   = (hi != '0) ? hi : bus.req_valid;
    found = |bus.req_valid;
    pick  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (src[i]) pick = IW'(i);
    end
  end

  always_comb begin
    ra = '0;
    rb = '0;
    for (int i = 0; i < N; i++) begin
      if (pick == IW'(i)) begin
        ra = bus.req_a[i*W +: W];
        rb = bus.req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    tmr_d   = tmr_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          g_d = pick;
          a_d = ra;
          b_d = rb;
          if (ra == '0 || rb == '0) begin
            data_d  = (ra == '0) ? rb : ra;
            err_d   = 1'b0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        tmr_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmr_d = tmr_q + 1'b1;
        if (bus.eng_done) begin
          data_d  = bus.eng_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmr_q == TW'(TMO - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready[g_q]) begin
          state_d = IDLE;
          rr_d    = (g_q == IW'(N - 1)) ? '0 : g_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      tmr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      tmr_q   <= tmr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  logic eng_act;
  assign eng_act = (state_q == ISSUE) || (state_q == WAIT);

  // Gate with rst so the grant is silent while reset is held.
  assign bus.req_ready = (rst && state_q == IDLE && found)
                       ? (N'(1) << pick) : '0;
  assign bus.rsp_valid = (state_q == RESP) ? (N'(1) << g_q) : '0;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign bus.eng_start = (state_q == ISSUE);
  assign bus.eng_a     = eng_act ? a_q : '0;
  assign bus.eng_b     = eng_act ? b_q : '0;
endmodule

// File: tb/tb_gcd_sched.sv
// tb_gcd_sched: scoreboard bench for gcd_sched.
// Expected responses are queued when requests are driven and popped on handshake.
module tb_gcd_sched;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gcd_sched_if #(.N(N), .W(W)) bus ();

  gcd_sched #(.N(N), .W(W), .TMO(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         g;
    logic [W-1:0] d;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;

  int         eng_lat = 2;
  bit         silent = 1'b0;
  bit         kick = 1'b0;
  int         cnt = 0;
  int         nstart = 0;
  logic [W-1:0] st_a = '0;
  logic [W-1:0] st_b = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] gcd(input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic [W-1:0] x = a;
    logic [W-1:0] y = b;
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine model: answers eng_lat cycles after start unless silent.
  initial begin
    bus.eng_done   = 1'b0;
    bus.eng_result = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.eng_done = 1'b0;
      if (!rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.eng_done   = 1'b1;
            bus.eng_result = gcd(st_a, st_b);
          end
        end
        if (kick) begin
          kick = 1'b0;
          bus.eng_done   = 1'b1;
          bus.eng_result = 32'd99;
        end
        if (bus.eng_start) begin
          nstart++;
          st_a = bus.eng_a;
          st_b = bus.eng_b;
          if (!silent) cnt = eng_lat;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on each rsp handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.req_ready != '0)
        chk("rdy_onehot", 64'($countones(bus.req_ready)), 64'd1);
      if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", 64'(bus.rsp_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_who", 64'(bus.rsp_valid), 64'(1 << e.g));
          chk("rsp_data", 64'(bus.rsp_data), 64'(e.d));
          chk("rsp_err", 64'(bus.rsp_err), 64'(e.e));
        end
      end
    end
  end

  task automatic set_req(input int g, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    bus.req_a[g*W +: W] = a;
    bus.req_b[g*W +: W] = b;
    bus.req_valid[g]    = 1'b1;
  endtask

  task automatic push(input int g, input logic [W-1:0] d, input logic e);
    exp_t x;
    x.g = g;
    x.d = d;
    x.e = e;
    sb.push_back(x);
  endtask

  task automatic drain(input int budget);
    logic [N-1:0] acc;
    int n = 0;
    while ((sb.size() != 0 || bus.req_valid != '0) && n < budget) begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #2;
      bus.req_valid = bus.req_valid & ~acc;
      n++;
    end
    if (n >= budget) chk("drain_tmo", 64'(sb.size()), 64'd0);
  endtask

  // Drive one request; lat = cycles from acceptance to first rsp_valid.
  task automatic req_lat(input int g, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ed,
                         input logic ee, output int lat);
    int t0 = 0;
    int n = 0;
    push(g, ed, ee);
    set_req(g, a, b);
    lat = -1;
    while (n < 50) begin
      @(negedge clk);
      if (bus.req_ready[g]) break;
      n++;
    end
    if (n >= 50) chk("grant_tmo", 64'(bus.req_ready), 64'(1 << g));
    t0 = cyc;
    @(posedge clk);
    #2;
    bus.req_valid[g] = 1'b0;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) break;
      n++;
    end
    if (n >= 400) chk("rsp_tmo", 64'(bus.rsp_valid), 64'(1 << g));
    lat = cyc - t0;
  endtask

  int ord[5] = '{0, 1, 2, 3, 0};
  int lat;
  int n0;
  int n;

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '1;
    for (int i = 0; i < N; i++) set_req(i, 12 * (i + 1), 18 * (i + 1));

    @(negedge clk);
    chk("rst_rdy", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_v", 64'(bus.rsp_valid), 64'd0);
    chk("rst_data", 64'({bus.rsp_err, bus.rsp_data}), 64'd0);
    chk("rst_eng", 64'({bus.eng_start, bus.eng_a, bus.eng_b}), 64'd0);

    // All four pending from reset release: round-robin 0,1,2,3,0.
    eng_lat = 2;
    for (int k = 0; k < 5; k++)
      push(ord[k], 6 * (ord[k] + 1), 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (n < 50) begin
        @(negedge clk);
        if (bus.req_ready != '0) break;
        n++;
      end
      chk("grant_order", 64'(bus.req_ready), 64'(1 << ord[k]));
      @(posedge clk);
      #2;
    end
    bus.req_valid = '0;
    drain(100);

    // Engine path: 69,81 -> 3, engine answers five cycles after start.
    @(posedge clk);
    #2;
    eng_lat = 5;
    n0 = nstart;
    req_lat(0, 69, 81, 3, 1'b0, lat);
    chk("lat_eng", 64'(lat), 64'd7);
    chk("eng_starts", 64'(nstart - n0), 64'd1);
    chk("eng_a", 64'(st_a), 64'd69);
    chk("eng_b", 64'(st_b), 64'd81);
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("eng_a_idle", 64'({bus.eng_a, bus.eng_b}), 64'd0);
    chk("rsp_v_idle", 64'(bus.rsp_valid), 64'd0);

    // Zero bypass: result next cycle, engine untouched.
    @(posedge clk);
    #2;
    n0 = nstart;
    req_lat(2, 0, 12, 12, 1'b0, lat);
    chk("lat_bypass", 64'(lat), 64'd1);
    chk("bypass_nostart", 64'(nstart - n0), 64'd0);
    @(posedge clk);
    #2;

    // Silent engine: abort after 255 WAIT cycles; late done ignored.
    silent = 1'b1;
    bus.rsp_ready = 4'b1101;
    req_lat(1, 7, 5, 0, 1'b1, lat);
    chk("lat_tmo", 64'(lat), 64'd257);
    @(posedge clk);
    #2;
    kick = 1'b1;
    repeat (3) @(negedge clk);
    chk("tmo_hold_v", 64'(bus.rsp_valid), 64'b0010);
    chk("tmo_hold_d", 64'({bus.rsp_err, bus.rsp_data}), 64'h1_0000_0000);
    @(posedge clk);
    #2;
    bus.rsp_ready = '1;
    @(negedge clk);
    @(posedge clk);
    #2;
    kick = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_done_ign", 64'(bus.rsp_valid), 64'd0);
    silent = 1'b0;

    // Backpressure in RESP while req3 waits.
    @(posedge clk);
    #2;
    eng_lat = 3;
    bus.rsp_ready = 4'b1110;
    req_lat(0, 9, 6, 3, 1'b0, lat);
    @(posedge clk);
    #2;
    push(3, 2, 1'b0);
    set_req(3, 10, 4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_v", 64'(bus.rsp_valid), 64'b0001);
      chk("bp_d", 64'({bus.rsp_err, bus.rsp_data}), 64'd3);
      chk("bp_rdy", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk);
    #2;
    bus.rsp_ready = '1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.req_ready != '0) break;
      n++;
    end
    chk("bp_grant3", 64'(bus.req_ready), 64'b1000);
    @(posedge clk);
    #2;
    bus.req_valid[3] = 1'b0;
    drain(100);

    // Bypass from req2 leaves rr pointing at requester 3.
    @(posedge clk);
    #2;
    req_lat(2, 5, 0, 5, 1'b0, lat);
    chk("lat_bypass_b0", 64'(lat), 64'd1);
    @(posedge clk);
    #2;

    // Reset during WAIT drops the transaction and restarts rr at 0.
    eng_lat = 20;
    set_req(3, 8, 12);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.eng_start) break;
      n++;
    end
    chk("pre_rst_start", 64'(bus.eng_start), 64'd1);
    @(posedge clk);
    #2;
    bus.req_valid[3] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_eng", 64'({bus.eng_start, bus.eng_a, bus.eng_b}), 64'd0);
    chk("arst_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_data}), 64'd0);
    push(1, 7, 1'b0);
    push(3, 4, 1'b0);
    set_req(1, 14, 21);
    set_req(3, 8, 12);
    @(negedge clk);
    chk("arst_rdy", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 64'(bus.req_ready), 64'b0010);
    @(posedge clk);
    #2;
    bus.req_valid[1] = 1'b0;
    drain(200);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/gcd_sched.md
GCD_SCHED -- requirements
Module: gcd_sched

Interface
REQ-001 Parameter N, default 4, number of requesters sharing one GCD engine.
REQ-002 Parameter W, default 32, operand and result width.
REQ-003 Parameter TMO, default 255, maximum WAIT cycles before abort.
REQ-004 clk  input  1  rising-edge clock; single clock domain.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  N  requester i holds a pending GCD request.
REQ-007 req_a  input  N*W  operand a, requester i at bits [i*W +: W].
REQ-008 req_b  input  N*W  operand b, same packing as req_a.
REQ-009 req_ready  output  N  one-hot accept; a request transfers on req_valid[i] && req_ready[i].
REQ-010 rsp_valid  output  N  one-hot result valid, addressed to the granted requester.
REQ-011 rsp_ready  input  N  requester i accepts its result.
REQ-012 rsp_data  output  W  GCD result.
REQ-013 rsp_err  output  1  high when the result is an engine timeout abort.
REQ-014 eng_start  output  1  one-cycle start pulse to the GCD engine.
REQ-015 eng_a, eng_b  output  W each  engine operands.
REQ-016 eng_done  input  1  engine result valid, one-cycle pulse.
REQ-017 eng_result  input  W  engine GCD result.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-019 In IDLE with any req_valid set, the block SHALL grant the first set bit searching upward from rr_ptr with wrap.
REQ-020 In that cycle it SHALL assert req_ready[g] combinationally for one cycle, latch req_a/req_b of g, and record g.
REQ-021 req_ready SHALL be zero in every state other than IDLE.
REQ-022 Zero bypass: if latched a==0, the result SHALL be b; if b==0, the result SHALL be a; if both are 0, the result SHALL be 0.
REQ-023 Under zero bypass the FSM SHALL go IDLE->RESP with rsp_err=0 and no eng_start, so rsp_valid is high in cycle T+1 after acceptance in cycle T.
REQ-024 When neither operand is zero, the FSM SHALL go IDLE->ISSUE.
REQ-025 In ISSUE, eng_start SHALL be 1 for exactly one cycle and the FSM SHALL then enter WAIT with the timer cleared.
REQ-026 eng_a/eng_b SHALL equal the latched operands from ISSUE through the end of WAIT, and 0 otherwise.
REQ-027 In WAIT the timer SHALL increment every cycle.
REQ-028 eng_done in WAIT SHALL latch eng_result into rsp_data with rsp_err=0, and the FSM SHALL go to RESP.
REQ-029 Latency: eng_done in WAIT cycle T+1+k (k>=1) SHALL give rsp_valid in cycle T+2+k.
REQ-030 If the TMO-th WAIT cycle ends without eng_done, the block SHALL set rsp_data=0 and rsp_err=1 and go to RESP.
REQ-031 If eng_done and the timeout occur in the same cycle, eng_done SHALL take priority.
REQ-032 eng_done outside WAIT SHALL be ignored.
REQ-033 In RESP, rsp_valid[g] SHALL be 1 and rsp_data/rsp_err SHALL be held stable until rsp_ready[g].
REQ-034 On the RESP handshake the FSM SHALL go to IDLE and set rr_ptr = (g+1) mod N.
REQ-035 rsp_ready bits other than g SHALL be ignored.
REQ-036 Only one transaction SHALL be outstanding; new requests SHALL wait until IDLE.
REQ-037 A requester SHALL hold req_valid and operands stable until accepted; dropping req_valid before grant SHALL have no effect.
REQ-038 The timer SHALL be wide enough for TMO without wrap-around.

Reset
REQ-039 While rst=0, all outputs SHALL be 0, state SHALL be IDLE, and rr_ptr, timer and latched operands SHALL be 0, asynchronously.
REQ-040 Reset mid-transaction SHALL drop the transaction with no response; eng_start SHALL fall immediately.
REQ-041 The first grant after reset release SHALL search from requester 0.

Verification
REQ-042 req0 a=69 b=81, engine returns 3 five cycles after start -> one eng_start with eng_a=69/eng_b=81; rsp_valid=0001, rsp_data=3, rsp_err=0.
REQ-043 All four req_valid held high from reset release with rsp_ready=1 -> grant order 0,1,2,3,0; never two req_ready bits high together.
REQ-044 req2 a=0 b=12 -> rsp_valid=0100, rsp_data=12 in the cycle after acceptance; eng_start never asserted.
REQ-045 req1 a=7 b=5, engine silent -> rsp_err=1, rsp_data=0 after 255 WAIT cycles; a later eng_done changes nothing.
REQ-046 rsp_ready low for 10 cycles in RESP while req3 is pending -> rsp_valid/rsp_data/rsp_err stable, no req_ready, req3 granted after handshake.
REQ-047 rst low during WAIT -> all outputs 0 at once; after release with req1 and req3 pending, req1 is granted first.
